// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// Module : ram_ctrl_pkg
// Brief  : Shared types and command opcodes for the RAM command arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD      = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_CMD  = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin grant selection with a priority pointer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_upd_idx,
    output logic       o_valid,
    output logic       o_idx
);

    // r_prio is the requester that wins the next tie; it moves away from
    // whoever was just served.
    logic r_prio;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_update) begin
            r_prio <= ~i_upd_idx;
        end
    end

    always_comb begin
        o_valid = |i_req;
        case (i_req)
            2'b01:   o_idx = 1'b0;
            2'b10:   o_idx = 1'b1;
            2'b11:   o_idx = r_prio;
            default: o_idx = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ram_cmd_arbiter.sv
// ============================================================================
// Module : ram_cmd_arbiter
// Brief  : Arbitrates two requesters onto a command-driven single-port RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ram_cmd_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          ack,
    output logic [DATA_W-1:0]   rdata,
    output logic                err,
    output logic                busy,
    output logic [9:0]          ram_din,
    output logic                ram_rx_valid,
    input  logic [DATA_W-1:0]   ram_dout,
    input  logic                ram_tx_valid
);

    localparam int              CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_grant;
    logic                w_arb_valid;
    logic                w_arb_idx;
    logic                r_gnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err_flag;
    logic [ADDR_W-1:0]   w_addr_sel;
    logic [DATA_W-1:0]   w_wdata_sel;
    logic [ADDR_W-1:0]   w_addr_src;
    logic [9:0]          w_din_nxt;
    logic                w_rxv_nxt;
    logic [1:0]          w_ack_nxt;

    logic [1:0]          r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic                r_busy;
    logic [9:0]          r_din;
    logic                r_rxv;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req),
        .i_update  (r_state == ST_DONE),
        .i_upd_idx (r_gnt),
        .o_valid   (w_arb_valid),
        .o_idx     (w_arb_idx)
    );

    assign w_addr_sel  = addr[int'(w_arb_idx)*ADDR_W +: ADDR_W];
    assign w_wdata_sel = wdata[int'(w_arb_idx)*DATA_W +: DATA_W];
    // The address command is issued the cycle after grant, before r_addr is loaded.
    assign w_addr_src  = (r_state == ST_IDLE) ? w_addr_sel : r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // No grant in the ack cycle: the finished requester still holds req.
                if (w_arb_valid && (r_ack == 2'b00)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = we[w_arb_idx] ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: w_state_nxt = ST_WR_DATA;
            ST_WR_DATA: w_state_nxt = ST_DONE;
            ST_RD_ADDR: w_state_nxt = ST_RD_CMD;
            ST_RD_CMD:  w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (ram_tx_valid || (r_cnt == c_LAST)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Commands are decoded from the next state so they line up with it.
    always_comb begin
        w_din_nxt = 10'd0;
        w_rxv_nxt = 1'b0;
        case (w_state_nxt)
            ST_WR_ADDR: begin
                w_din_nxt = {CMD_WR_ADDR, 8'(w_addr_src)};
                w_rxv_nxt = 1'b1;
            end
            ST_WR_DATA: begin
                w_din_nxt = {CMD_WR_DATA, 8'(r_wdata)};
                w_rxv_nxt = 1'b1;
            end
            ST_RD_ADDR: begin
                w_din_nxt = {CMD_RD_ADDR, 8'(w_addr_src)};
                w_rxv_nxt = 1'b1;
            end
            ST_RD_CMD: begin
                w_din_nxt = {CMD_RD, 8'h00};
                w_rxv_nxt = 1'b1;
            end
            default: begin
                w_din_nxt = 10'd0;
                w_rxv_nxt = 1'b0;
            end
        endcase
    end

    assign w_ack_nxt = (r_state == ST_DONE) ? (2'b01 << r_gnt) : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_err_flag <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_grant) begin
                r_gnt      <= w_arb_idx;
                r_addr     <= w_addr_sel;
                r_wdata    <= w_wdata_sel;
                r_err_flag <= 1'b0;
            end
            if (r_state == ST_RD_CMD) begin
                r_cnt <= '0;
            end else if ((r_state == ST_RD_WAIT) && !ram_tx_valid) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == ST_RD_WAIT) begin
                if (ram_tx_valid) begin
                    r_rdata <= ram_dout;
                end else if (r_cnt == c_LAST) begin
                    r_rdata    <= '0;
                    r_err_flag <= 1'b1;
                end
            end
        end
    end

    // Busy covers the ack cycle, which follows DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack  <= 2'b00;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
            r_din  <= 10'd0;
            r_rxv  <= 1'b0;
        end else begin
            r_ack  <= w_ack_nxt;
            r_err  <= (r_state == ST_DONE) && r_err_flag;
            r_busy <= (w_state_nxt != ST_IDLE) || (r_state == ST_DONE);
            r_din  <= w_din_nxt;
            r_rxv  <= w_rxv_nxt;
        end
    end

    assign ack          = r_ack;
    assign rdata        = r_rdata;
    assign err          = r_err;
    assign busy         = r_busy;
    assign ram_din      = r_din;
    assign ram_rx_valid = r_rxv;

endmodule

`default_nettype wire

// File: tb/tb_ram_cmd_arbiter.sv
// ============================================================================
// Module : tb_ram_cmd_arbiter
// Brief  : Directed self-checking bench with a behavioural command RAM.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ram_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [15:0] addr = 16'h0;
    logic [15:0] wdata = 16'h0;
    logic [1:0]  ack;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic [7:0]  ram_dout;
    logic        ram_tx_valid;

    int n_checks = 0;
    int n_errors = 0;

    ram_cmd_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr         (addr),
        .wdata        (wdata),
        .ack          (ack),
        .rdata        (rdata),
        .err          (err),
        .busy         (busy),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural command RAM: opcode 11 raises tx_valid whether or not rx_valid is set.
    logic [7:0] mem [256];
    logic [7:0] ram_wa = 8'h0;
    logic [7:0] ram_ra = 8'h0;
    logic       ram_tx_raw = 1'b0;
    logic       no_tx = 1'b0;

    always @(posedge clk) begin
        ram_tx_raw <= (ram_din[9:8] == 2'b11);
        if (ram_din[9:8] == 2'b11) ram_dout <= mem[ram_ra];
        if (ram_rx_valid) begin
            case (ram_din[9:8])
                2'b00:   ram_wa <= ram_din[7:0];
                2'b01:   mem[ram_wa] <= ram_din[7:0];
                2'b10:   ram_ra <= ram_din[7:0];
                default: ;
            endcase
        end
    end
    assign ram_tx_valid = ram_tx_raw & ~no_tx;

    logic [9:0] cmdq[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (!ram_rx_valid) check("din_idle", {22'd0, ram_din}, 32'd0);
            else cmdq.push_back(ram_din);
            check("ack_onehot", {31'd0, ack == 2'b11}, 32'd0);
        end
    end

    task automatic run_txn(input int r, input logic w, input logic [7:0] a, input logic [7:0] d,
                           input logic poke, output int lat, output logic [7:0] rd, output logic e);
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {31'd0, n < 20}, 32'd1);
        req[r] = 1'b1;
        we[r] = w;
        addr[r*8 +: 8] = a;
        wdata[r*8 +: 8] = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (poke && lat == 1) begin
                addr[r*8 +: 8] = ~a;
                wdata[r*8 +: 8] = ~d;
            end
        end while (!ack[r] && lat < 30);
        rd = rdata;
        e = err;
        lat = lat - 1;
        req[r] = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 2'b00 && n < 30);
        check("ack_timeout", {31'd0, n < 30}, 32'd1);
    endtask

    int         lat;
    int         n;
    logic [7:0] rd;
    logic       e;
    logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        #1;
        check("rst_ack", {30'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_din", {22'd0, ram_din}, 32'd0);
        check("rst_rxv", {31'd0, ram_rx_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back through the RAM model
        cmdq.delete();
        run_txn(0, 1'b1, 8'h3C, 8'hA5, 1'b0, lat, rd, e);
        check("wr_latency", lat, 32'd3);
        check("wr_cmd_count", cmdq.size(), 32'd2);
        if (cmdq.size() == 2) begin
            check("wr_cmd0", {22'd0, cmdq[0]}, 32'h03C);
            check("wr_cmd1", {22'd0, cmdq[1]}, 32'h1A5);
        end
        cmdq.delete();
        run_txn(1, 1'b0, 8'h3C, 8'h00, 1'b0, lat, rd, e);
        check("rd_latency", lat, 32'd4);
        check("rd_data", {24'd0, rd}, 32'hA5);
        check("rd_err", {31'd0, e}, 32'd0);
        check("rd_cmd_count", cmdq.size(), 32'd2);
        if (cmdq.size() == 2) begin
            check("rd_cmd0", {22'd0, cmdq[0]}, 32'h23C);
            check("rd_cmd1", {22'd0, cmdq[1]}, 32'h300);
        end

        // Continuous contention, mixed read/write
        @(negedge clk);
        we = 2'b01;
        addr = {8'h3C, 8'h10};
        wdata = {8'h00, 8'h11};
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(n);
            check("rr_grant", {30'd0, ack}, {30'd0, exp_gnt[k]});
            if (k == 1) check("rr_rd1", {24'd0, rdata}, 32'hA5);
            if (k == 2) check("rr_rd2", {24'd0, rdata}, 32'h11);
            if (k == 0) we[0] = 1'b0;
            if (k == 1) begin
                we[1] = 1'b1;
                addr[15:8] = 8'h20;
                wdata[15:8] = 8'h22;
            end
            if (k == 3) req = 2'b00;
            @(negedge clk);
            check("rr_busy_gap", {31'd0, busy}, 32'd0);
            if (k < 3) begin
                @(negedge clk);
                check("rr_busy_again", {31'd0, busy}, 32'd1);
            end
        end

        // Read timeout
        no_tx = 1'b1;
        run_txn(0, 1'b0, 8'h3C, 8'h00, 1'b0, lat, rd, e);
        check("to_latency", lat, 32'd7);
        check("to_err", {31'd0, e}, 32'd1);
        check("to_rdata", {24'd0, rd}, 32'd0);
        no_tx = 1'b0;
        @(negedge clk);
        check("to_idle", {31'd0, busy}, 32'd0);
        check("to_err_pulse", {31'd0, err}, 32'd0);

        // Reset during WR_DATA, then a tie goes to requester 0
        we[1] = 1'b1;
        addr[15:8] = 8'h77;
        wdata[15:8] = 8'h88;
        req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_wrdata", {22'd0, ram_din}, 32'h188);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rxv", {31'd0, ram_rx_valid}, 32'd0);
        check("mid_rst_din", {22'd0, ram_din}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        we = 2'b00;
        addr = {8'h3C, 8'h3C};
        req = 2'b11;
        wait_ack(n);
        check("post_rst_grant", {30'd0, ack}, 32'd1);
        req = 2'b00;
        @(negedge clk);

        // Inputs changed while busy must not reach the RAM
        cmdq.delete();
        run_txn(0, 1'b1, 8'h55, 8'h66, 1'b1, lat, rd, e);
        check("poke_cmd_count", cmdq.size(), 32'd2);
        if (cmdq.size() == 2) begin
            check("poke_cmd0", {22'd0, cmdq[0]}, 32'h055);
            check("poke_cmd1", {22'd0, cmdq[1]}, 32'h166);
        end
        run_txn(1, 1'b0, 8'h55, 8'h00, 1'b0, lat, rd, e);
        check("poke_readback", {24'd0, rd}, 32'h66);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
